vga_sync_gen: RTL and testbench

- Producer end of the `vga` interface; drives the `vga.out` modport toward the board VGA pin stage.
- Runs horizontal/vertical raster counters with sync pulses, and exports draw coordinates to the game renderer.
- Delays sync/coordinate signals by the renderer's fixed latency so they align with returned colour.
- Blanks colour outside the active area; default timing is 640x480@60 on a 25 MHz pixel cadence.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_if.sv | 16 +
 rtl/vga_delay_line.sv | 30 +++
 rtl/vga_sync_gen.sv | 152 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing: 640x480@60 defaults, total-period helper and sync polarity.
package vga_timing_pkg;

  localparam int VGA_WIDTH  = 640;
  localparam int VGA_HEIGHT = 480;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Raster bundle from the sync generator to the board VGA pin stage.
interface vga #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
);
  logic                      hsync;
  logic                      vsync;
  logic [$clog2(WIDTH)-1:0]  pxl_x;
  logic [$clog2(HEIGHT)-1:0] pxl_y;
  logic [3:0]                red;
  logic [3:0]                green;
  logic [3:0]                blue;

  modport out (output hsync, vsync, pxl_x, pxl_y, red, green, blue);
  modport in  (input  hsync, vsync, pxl_x, pxl_y, red, green, blue);
endinterface

// File: rtl/vga_delay_line.sv
// Enable-qualified shift register with async clear; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counters, sync generation and colour blanking, with sync/coords delayed to
// line up with the renderer's colour return.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int WIDTH      = VGA_WIDTH,
  parameter int HEIGHT     = VGA_HEIGHT,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit SYNC_POL   = bit'(SYNC_ACTIVE_LOW),
  parameter int RENDER_LAT = 1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      pxl_ce,
  output logic [$clog2(WIDTH)-1:0]  draw_x,
  output logic [$clog2(HEIGHT)-1:0] draw_y,
  output logic                      draw_valid,
  input  logic [3:0]                red_in,
  input  logic [3:0]                green_in,
  input  logic [3:0]                blue_in,
  output logic                      frame_start,
  vga.out                           vga_o
);

  localparam int H_TOTAL = vga_total(WIDTH, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(HEIGHT, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int BW = 3 + XW + YW;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(WIDTH);
  localparam logic [HW-1:0] H_SS   = HW'(WIDTH + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(WIDTH + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(HEIGHT);
  localparam logic [VW-1:0] V_SS   = VW'(HEIGHT + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(HEIGHT + V_FP + V_SYNC);

  if (RENDER_LAT < 0 || RENDER_LAT > 4 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_err
    $error("vga_sync_gen: RENDER_LAT must be 0..4 and porch/sync widths non-zero");
  end

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          frame_start_q, frame_start_d;
  logic          h_last, v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pxl_ce) begin
      if (h_last) begin
        h_cnt_d       = '0;
        v_cnt_d       = v_last ? '0 : v_cnt_q + 1'b1;
        frame_start_d = v_last;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

  logic active, hs0, vs0;
  assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs0    = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
  assign vs0    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);

  assign draw_valid = active;
  assign draw_x     = active ? h_cnt_q[XW-1:0] : '0;
  assign draw_y     = active ? v_cnt_q[YW-1:0] : '0;

  // Sync is carried as "asserted" bits so the cleared delay line reads as inactive.
  logic [BW-1:0]   s0_bus, sd_bus;
  logic            sd_hs, sd_vs, sd_act;
  logic [XW-1:0]   sd_x;
  logic [YW-1:0]   sd_y;

  assign s0_bus = {hs0, vs0, active, draw_x, draw_y};

  vga_delay_line #(
    .DEPTH (RENDER_LAT),
    .WIDTH (BW)
  ) u_delay (
    .clk    (clk),
    .resetN (resetN),
    .ce_i   (pxl_ce),
    .d_i    (s0_bus),
    .q_o    (sd_bus)
  );

  assign {sd_hs, sd_vs, sd_act, sd_x, sd_y} = sd_bus;

  logic          hsync_q, vsync_q;
  logic [XW-1:0] pxl_x_q;
  logic [YW-1:0] pxl_y_q;
  logic [3:0]    red_q, green_q, blue_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      pxl_x_q <= '0;
      pxl_y_q <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pxl_ce) begin
      hsync_q <= sd_hs ? SYNC_POL : ~SYNC_POL;
      vsync_q <= sd_vs ? SYNC_POL : ~SYNC_POL;
      pxl_x_q <= sd_x;
      pxl_y_q <= sd_y;
      red_q   <= sd_act ? red_in   : 4'h0;
      green_q <= sd_act ? green_in : 4'h0;
      blue_q  <= sd_act ? blue_in  : 4'h0;
    end
  end

  assign vga_o.hsync = hsync_q;
  assign vga_o.vsync = vsync_q;
  assign vga_o.pxl_x = pxl_x_q;
  assign vga_o.pxl_y = pxl_y_q;
  assign vga_o.red   = red_q;
  assign vga_o.green = green_q;
  assign vga_o.blue  = blue_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken 16x8 raster (24x13 totals, 312-pixel frame).
module tb_vga_sync_gen;

  localparam int W = 16, H = 8;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       pxl_ce = 1'b0;
  logic [3:0] draw_x;
  logic [2:0] draw_y;
  logic       draw_valid;
  logic [3:0] red_in, green_in, blue_in;
  logic       frame_start;

  vga #(.WIDTH(W), .HEIGHT(H)) vga_bus ();

  vga_sync_gen #(
    .WIDTH(W), .HEIGHT(H), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .RENDER_LAT(LAT)
  ) dut (
    .clk(clk), .resetN(resetN), .pxl_ce(pxl_ce),
    .draw_x(draw_x), .draw_y(draw_y), .draw_valid(draw_valid),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .frame_start(frame_start), .vga_o(vga_bus)
  );

  always #20 clk = ~clk;

  // Renderer model: red returns draw_x two pixel-enables later.
  logic [3:0] xpipe0, xpipe1;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      xpipe0 <= 4'h0;
      xpipe1 <= 4'h0;
    end else if (pxl_ce) begin
      xpipe0 <= draw_x;
      xpipe1 <= xpipe0;
    end
  end
  assign red_in   = xpipe1;
  assign green_in = 4'hF;
  assign blue_in  = 4'hA;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] out_vec();
    return {vga_bus.hsync, vga_bus.vsync, vga_bus.red, vga_bus.green,
            vga_bus.blue, vga_bus.pxl_x, vga_bus.pxl_y};
  endfunction

  task automatic wait_fs(input bit toggle, output int n);
    n = 0;
    do begin
      tick();
      if (toggle) pxl_ce = ~pxl_ce;
      n++;
    end while (!frame_start && n < 2000);
    if (!frame_start) n = -1;
  endtask

  int hs_low, hs_fall, vs_low, vs_fall, act_cnt, bad_col, last_px, bad_blank, fs_cnt, held_bad;

  task automatic frame_stats(input int cycles, input bit toggle);
    logic        ph, pv, ce_prev;
    logic [20:0] snap;
    hs_low = 0; hs_fall = 0; vs_low = 0; vs_fall = 0; act_cnt = 0;
    bad_col = 0; last_px = 0; bad_blank = 0; fs_cnt = 0; held_bad = 0;
    for (int i = 0; i < cycles; i++) begin
      ph = vga_bus.hsync;
      pv = vga_bus.vsync;
      ce_prev = pxl_ce;
      snap = out_vec();
      tick();
      if (toggle) pxl_ce = ~pxl_ce;
      if (!vga_bus.hsync) hs_low++;
      if (ph && !vga_bus.hsync) hs_fall++;
      if (!vga_bus.vsync) vs_low++;
      if (pv && !vga_bus.vsync) vs_fall++;
      if (vga_bus.green == 4'hF) begin
        act_cnt++;
        if (vga_bus.red != vga_bus.pxl_x) bad_col++;
        if (vga_bus.blue != 4'hA) bad_col++;
        if (vga_bus.pxl_x == 4'd15 && vga_bus.pxl_y == 3'd7) last_px++;
      end else if (vga_bus.red != 0 || vga_bus.blue != 0 || vga_bus.pxl_x != 0 || vga_bus.pxl_y != 0) begin
        bad_blank++;
      end
      if (frame_start) fs_cnt++;
      if (!ce_prev && out_vec() != snap) held_bad++;
    end
  endtask

  initial begin
    int n, m, n2, x15, v16;

    pxl_ce = 1'b1;
    resetN = 1'b0;
    repeat (10) tick();
    chk("rst_hsync", vga_bus.hsync, 1);
    chk("rst_vsync", vga_bus.vsync, 1);
    chk("rst_red", vga_bus.red, 0);
    chk("rst_green", vga_bus.green, 0);
    chk("rst_pxl_x", vga_bus.pxl_x, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_draw_valid", draw_valid, 1);

    @(negedge clk);
    resetN = 1'b1;
    n = 0; x15 = -1; v16 = -1;
    do begin
      tick();
      n++;
      if (n == 15) x15 = draw_x;
      if (n == 16) v16 = draw_valid;
    end while (vga_bus.hsync && n < 200);
    chk("first_hs_fall", n, 21);
    chk("draw_x_last_col", x15, 15);
    chk("draw_valid_col_w", v16, 0);
    m = 0;
    do begin
      tick();
      m++;
    end while (!vga_bus.hsync && m < 50);
    chk("hs_width", m, 3);
    wait_fs(1'b0, n2);
    chk("first_fs_edge", (n2 < 0) ? -1 : n + m + n2, 312);

    frame_stats(312, 1'b0);
    chk("f_hs_low", hs_low, 39);
    chk("f_hs_fall", hs_fall, 13);
    chk("f_vs_low", vs_low, 48);
    chk("f_vs_fall", vs_fall, 1);
    chk("f_active", act_cnt, 128);
    chk("f_colour_align", bad_col, 0);
    chk("f_last_px", last_px, 1);
    chk("f_blank", bad_blank, 0);
    chk("f_fs_pulses", fs_cnt, 1);
    wait_fs(1'b0, n);
    chk("fs_period", n, 312);

    pxl_ce = 1'b0;
    wait_fs(1'b1, n);
    chk("ce2_fs_found", (n > 0) ? 1 : 0, 1);
    frame_stats(624, 1'b1);
    chk("c_hs_low", hs_low, 78);
    chk("c_hs_fall", hs_fall, 13);
    chk("c_vs_low", vs_low, 96);
    chk("c_active", act_cnt, 256);
    chk("c_colour_align", bad_col, 0);
    chk("c_last_px", last_px, 2);
    chk("c_blank", bad_blank, 0);
    chk("c_fs_pulses", fs_cnt, 1);
    chk("c_held", held_bad, 0);
    wait_fs(1'b1, n);
    chk("c_fs_period", n, 624);

    pxl_ce = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (vga_bus.vsync && n < 2000);
    chk("mid_vs_seen", vga_bus.vsync, 0);
    repeat (20) tick();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("mid_rst_vsync", vga_bus.vsync, 1);
    chk("mid_rst_hsync", vga_bus.hsync, 1);
    chk("mid_rst_pxl_y", vga_bus.pxl_y, 0);
    chk("mid_rst_green", vga_bus.green, 0);
    chk("mid_rst_fs", frame_start, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    wait_fs(1'b0, n);
    chk("mid_first_fs", n, 312);
    wait_fs(1'b0, n);
    chk("mid_fs_period", n, 312);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
